// File: rtl/load_use_scoreboard.sv
// rtl/load_use_scoreboard.sv - per-register load-use pending scoreboard with decode stall/bubble handshake
// Optional feature macro: LOAD_USE_PERF_CNT_EN (adds the stall_cycles output)
module load_use_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NRP      = 2,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    input  logic              issue_regwrite,
    input  logic              issue_is_load,
    input  logic [NRP*AW-1:0] src_addr,
    input  logic [NRP-1:0]    src_used,
    input  logic              flush,
    output logic              stall,
    output logic              issue_accept,
    output logic              bubble,
`ifdef LOAD_USE_PERF_CNT_EN
    output logic [31:0]       stall_cycles,
`endif
    output logic [NREG-1:0]   pending
);

    // Register 0 is never tracked, so the array starts at 1.
    logic [CW-1:0] cnt [1:NREG-1];
    logic          hit;

    // Matching against every tracked index keeps out-of-range addresses from ever hitting.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NRP; i++) begin
            for (int r = 1; r < NREG; r++) begin
                if (src_used[i] && (src_addr[i*AW +: AW] == AW'(r)) && (cnt[r] != '0))
                    hit = 1'b1;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < NREG; r++)
            pending[r] = (cnt[r] != '0);
    end

    assign stall        = issue_valid & hit;
    assign issue_accept = issue_valid & ~stall & ~flush;
    assign bubble       = issue_valid & stall & ~flush;

    // An accepted non-load write clears its rd: the younger result supersedes the pending load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 1; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (flush)
                    cnt[r] <= '0;
                else if (issue_accept && issue_regwrite && (issue_rd == AW'(r)))
                    cnt[r] <= issue_is_load ? CW'(LOAD_LAT) : '0;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

`ifdef LOAD_USE_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb/tb_load_use_scoreboard.sv - scoreboard bench for load_use_scoreboard, LOAD_LAT=1 and LOAD_LAT=3 instances
module tb_load_use_scoreboard;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              issue_valid = 1'b0;
    logic [AW-1:0]     issue_rd = '0;
    logic              issue_regwrite = 1'b0;
    logic              issue_is_load = 1'b0;
    logic [2*AW-1:0]   src_addr = '0;
    logic [1:0]        src_used = '0;
    logic              flush = 1'b0;

    logic [1:0]        stall_o, acc_o, bub_o;
    logic [NREG-1:0]   pend0, pend1;
`ifdef LOAD_USE_PERF_CNT_EN
    logic [31:0]       sc0, sc1;
`endif

    always #5 clk = ~clk;

    load_use_scoreboard #(.NREG(NREG), .AW(AW), .NRP(2), .LOAD_LAT(1), .CW(4)) u_lat1 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .issue_is_load(issue_is_load),
        .src_addr(src_addr), .src_used(src_used), .flush(flush),
        .stall(stall_o[0]), .issue_accept(acc_o[0]), .bubble(bub_o[0]),
`ifdef LOAD_USE_PERF_CNT_EN
        .stall_cycles(sc0),
`endif
        .pending(pend0));

    load_use_scoreboard #(.NREG(NREG), .AW(AW), .NRP(2), .LOAD_LAT(3), .CW(4)) u_lat3 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .issue_is_load(issue_is_load),
        .src_addr(src_addr), .src_used(src_used), .flush(flush),
        .stall(stall_o[1]), .issue_accept(acc_o[1]), .bubble(bub_o[1]),
`ifdef LOAD_USE_PERF_CNT_EN
        .stall_cycles(sc1),
`endif
        .pending(pend1));

    typedef struct packed {
        logic [1:0]      stall;
        logic [1:0]      acc;
        logic [1:0]      bub;
        logic [NREG-1:0] pend1;
        logic [NREG-1:0] pend0;
        logic [31:0]     perf1;
        logic [31:0]     perf0;
    } exp_t;

    exp_t   q[$];
    int     tests = 0;
    int     fails = 0;

    // Model: each register is unavailable until an absolute cycle number.
    longint ready [2][NREG];
    longint perf  [2];
    longint cyc = 0;
    int     lat   [2] = '{1, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall",   {62'd0, stall_o}, {62'd0, e.stall});
            chk("accept",  {62'd0, acc_o},   {62'd0, e.acc});
            chk("bubble",  {62'd0, bub_o},   {62'd0, e.bub});
            chk("pending", {pend1, pend0},   {e.pend1, e.pend0});
`ifdef LOAD_USE_PERF_CNT_EN
            chk("stall_cycles", {sc1, sc0}, {e.perf1, e.perf0});
`endif
        end
    end

    task automatic step(input logic v, input logic [AW-1:0] rd, input logic rw, input logic ld,
                        input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic [1:0] used,
                        input logic fl, input logic rs, output logic [1:0] acc_x);
        exp_t e;
        logic [AW-1:0] s [2];
        @(posedge clk);
        #1;
        reset = rs; issue_valid = v; issue_rd = rd; issue_regwrite = rw; issue_is_load = ld;
        src_addr = {s1, s0}; src_used = used; flush = fl;
        s[0] = s0; s[1] = s1;
        if (rs) begin
            for (int k = 0; k < 2; k++) begin
                perf[k] = 0;
                for (int r = 0; r < NREG; r++) ready[k][r] = 0;
            end
        end
        e = '0;
        for (int k = 0; k < 2; k++) begin
            logic h;
            h = 1'b0;
            for (int i = 0; i < 2; i++)
                if (used[i] && s[i] != 0 && int'(s[i]) < NREG && cyc < ready[k][s[i]]) h = 1'b1;
            e.stall[k] = v & h;
            e.acc[k]   = v & ~h & ~fl;
            e.bub[k]   = v & h & ~fl;
            for (int r = 1; r < NREG; r++) begin
                if (k == 0) e.pend0[r] = (cyc < ready[0][r]);
                else        e.pend1[r] = (cyc < ready[1][r]);
            end
        end
        e.perf0 = 32'(perf[0]);
        e.perf1 = 32'(perf[1]);
        q.push_back(e);
        acc_x = e.acc;
        if (!rs) begin
            for (int k = 0; k < 2; k++) begin
                if (e.stall[k] && perf[k] < 64'hFFFF_FFFF) perf[k]++;
                if (fl) begin
                    for (int r = 0; r < NREG; r++) ready[k][r] = 0;
                end else if (e.acc[k] && rw && rd != 0) begin
                    ready[k][rd] = ld ? cyc + 1 + lat[k] : 0;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic [1:0] a;
        repeat (n) step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, a);
    endtask

    // Re-presents the same instruction until instance k accepts it, within a bounded number of cycles.
    task automatic issue_until(input int k, input logic [AW-1:0] rd, input logic rw, input logic ld,
                               input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic [1:0] used);
        logic [1:0] a;
        int n;
        n = 0;
        do begin
            step(1, rd, rw, ld, s0, s1, used, 0, 0, a);
            n++;
        end while (!a[k] && n < 20);
        chk("issue_bound", {63'd0, a[k]}, 64'd1);
    endtask

    initial begin
        logic [1:0] a;
        for (int k = 0; k < 2; k++) begin
            perf[k] = 0;
            for (int r = 0; r < NREG; r++) ready[k][r] = 0;
        end
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, a);
        step(1, 3, 1, 1, 3, 3, 2'b11, 0, 1, a);
        idle(1);

        // Basic load-use on rd=5
        step(1, 5, 1, 1, 0, 0, 2'b00, 0, 0, a);
        issue_until(0, 1, 1, 0, 5, 0, 2'b01);
        idle(4);

        // Long-latency load rd=7, independent then dependent instruction
        step(1, 7, 1, 1, 0, 0, 2'b00, 0, 0, a);
        step(1, 10, 1, 0, 2, 3, 2'b11, 0, 0, a);
        issue_until(1, 11, 1, 0, 2, 7, 2'b11);
        idle(4);

        // x0 and unused sources never hazard
        step(1, 0, 1, 1, 0, 0, 2'b00, 0, 0, a);
        step(1, 12, 1, 0, 0, 0, 2'b11, 0, 0, a);
        step(1, 5, 1, 1, 0, 0, 2'b00, 0, 0, a);
        step(1, 12, 1, 0, 5, 5, 2'b00, 0, 0, a);
        step(1, 13, 0, 1, 0, 0, 2'b00, 0, 0, a);
        step(1, 12, 1, 0, 13, 13, 2'b11, 0, 0, a);
        idle(4);

        // WAW: non-load write supersedes pending load
        step(1, 9, 1, 1, 0, 0, 2'b00, 0, 0, a);
        step(1, 9, 1, 0, 1, 2, 2'b11, 0, 0, a);
        step(1, 14, 1, 0, 9, 9, 2'b11, 0, 0, a);
        idle(4);

        // Flush with a dependent instruction, then replay
        step(1, 4, 1, 1, 0, 0, 2'b00, 0, 0, a);
        step(1, 15, 1, 0, 4, 0, 2'b01, 1, 0, a);
        step(1, 15, 1, 0, 4, 0, 2'b01, 0, 0, a);
        idle(4);

        // Reset asserted mid-stall
        step(1, 6, 1, 1, 0, 0, 2'b00, 0, 0, a);
        step(1, 16, 1, 0, 6, 0, 2'b01, 0, 0, a);
        step(1, 16, 1, 0, 6, 0, 2'b01, 0, 1, a);
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, a);
        idle(2);

        // Randomised traffic over a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] rd, s0, s1;
            rd = AW'($urandom_range(0, 7));
            s0 = ($urandom_range(0, 9) == 0) ? AW'(31) : AW'($urandom_range(0, 7));
            s1 = AW'($urandom_range(0, 7));
            step(($urandom_range(0, 9) < 8), rd, 1'($urandom), ($urandom_range(0, 2) != 0),
                 s0, s1, 2'($urandom), ($urandom_range(0, 24) == 0), 0, a);
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
